cac_dec_sched: RTL

- Sequencer that shares one combinational Fibonacci-CAC decoder (9-bit codeword, per-bit enable, FNS-weighted sum) across G codeword groups of a wide bus word.
- Accepts a bus word plus per-group enable masks over a valid/ready handshake.
- Drives the decoder one group per cycle and captures each decoded value into an output register bank.
- Presents the assembled data word over a second valid/ready handshake. Sits between the link receiver and the data sink.

---
 rtl/cac_dec_sched_pkg.sv | 6 +
 rtl/cac_dec_sched.sv | 65 ++++++
 2 files changed

// File: rtl/cac_dec_sched_pkg.sv
// cac_dec_sched_pkg: shared state encoding and default Fibonacci-CAC widths
package cac_dec_sched_pkg;
  localparam int CAC_CW = 9;
  localparam int CAC_DW = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/cac_dec_sched.sv
// cac_dec_sched: time-shares one external Fibonacci-CAC decoder across G codeword groups
module cac_dec_sched
  import cac_dec_sched_pkg::*;
#(
  parameter int G  = 4,
  parameter int CW = CAC_CW,
  parameter int DW = CAC_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [G*CW-1:0] in_code,
  input  logic [G*CW-1:0] in_en,
  output logic [CW-1:0]   dec_codein,
  output logic [CW-1:0]   dec_en,
  input  logic [DW-1:0]   dec_dataout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [G*DW-1:0] out_data,
  output logic            busy
);
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  state_t          state, state_nx;
  logic [GW-1:0]   grp;
  logic            rdy_q;
  logic [G*CW-1:0] code_q, en_q;
  logic [G*DW-1:0] data_q;
  logic            last, take;
  assign last       = grp == GW'(G - 1);
  assign busy       = state == RUN;
  assign out_valid  = state == DONE;
  assign out_data   = data_q;
  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready   = rdy_q & ((state == IDLE) | ((state == DONE) & out_ready));
  assign take       = in_valid & in_ready;
  assign dec_codein = busy ? code_q[grp*CW +: CW] : '0;
  assign dec_en     = busy ? en_q[grp*CW +: CW] : '0;
  always_comb begin
    state_nx = take ? RUN : (busy & last) ? DONE : (out_valid & out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      grp    <= '0;
      code_q <= '0;
      en_q   <= '0;
      data_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (take) begin
        code_q <= in_code;
        en_q   <= in_en;
        grp    <= '0;
      end else if (busy) begin
        data_q[grp*DW +: DW] <= dec_dataout;
        grp                  <= last ? '0 : grp + 1'b1;
      end
    end
  end
endmodule
